// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
// Module : hamming_pkg
// Hamming(21,16) widths, word types and a reference encoder.
// Rev    : 1.0
// ============================================================================
package hamming_pkg;

  localparam int DATA_W = 16;
  localparam int ENC_W  = 21;

  typedef logic [ENC_W-1:0]  codeword_t;
  typedef logic [DATA_W-1:0] dataword_t;

  // Codeword position p (1-based) holds parity when p is a power of two,
  // otherwise the next data bit in ascending order.
  function automatic codeword_t hamming_encode(input dataword_t d);
    codeword_t  cw;
    logic [3:0] k;
    logic [4:0] pos;
    logic       par;
    cw = '0;
    k  = '0;
    for (int i = 0; i < ENC_W; i++) begin
      pos = 5'(i + 1);
      if ((pos & (pos - 5'd1)) != 5'd0) begin
        cw[i] = d[k];
        k     = k + 4'd1;
      end
    end
    for (int b = 0; b < 5; b++) begin
      par = 1'b0;
      for (int i = 0; i < ENC_W; i++) begin
        pos = 5'(i + 1);
        if (pos[b]) par = par ^ cw[i];
      end
      cw[(1 << b) - 1] = par;
    end
    return cw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Round-robin one-hot arbiter; owns the rotating priority pointer.
// Rev    : 1.0
// ============================================================================
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    ptr_d     = ptr_q;
    if (en) begin
      // Scan from the far end back so the candidate nearest the pointer wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
        if (req[cand]) begin
          gnt_idx   = cand;
          gnt_valid = 1'b1;
        end
      end
    end
    if (gnt_valid) begin
      gnt[gnt_idx] = 1'b1;
      ptr_d        = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule
`default_nettype wire

// File: rtl/hamming_dec_arbiter.sv
`default_nettype none
// ============================================================================
// Module : hamming_dec_arbiter
// Shares one Hamming(21,16) decoder among NUM_REQ requesters with credit-
// protected, in-order responses. Optional grant statistics: HAMMING_ARB_STATS_EN.
// Rev    : 1.0
// ============================================================================
module hamming_dec_arbiter
  import hamming_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int RSP_DEPTH = 4,
  parameter  int DEC_LAT   = 1,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*ENC_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [ENC_W-1:0]         dec_encoded_data,
  output logic                     dec_valid_in,
  input  logic [DATA_W-1:0]        dec_decoded_data,
  input  logic                     dec_valid_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [ID_W-1:0]          rsp_id,
`ifdef HAMMING_ARB_STATS_EN
  input  logic [ID_W-1:0]          stat_sel,
  input  logic                     stat_clr,
  output logic [15:0]              stat_grants,
`endif
  output logic                     proto_err
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = $clog2(DEC_LAT + 2);

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_valid;
  logic               credit_ok;

  logic               dec_valid_in_q, dec_valid_in_d;
  logic [ENC_W-1:0]   dec_encoded_data_q, dec_encoded_data_d;
  logic [ID_W-1:0]    issue_tag_q, issue_tag_d;
  logic               tag_v_q  [DEC_LAT];
  logic               tag_v_d  [DEC_LAT];
  logic [ID_W-1:0]    tag_id_q [DEC_LAT];
  logic [ID_W-1:0]    tag_id_d [DEC_LAT];
  logic [CNT_W-1:0]   inflight_q, inflight_d;
  logic [DATA_W-1:0]  mem_data_q [RSP_DEPTH];
  logic [DATA_W-1:0]  mem_data_d [RSP_DEPTH];
  logic [ID_W-1:0]    mem_id_q   [RSP_DEPTH];
  logic [ID_W-1:0]    mem_id_d   [RSP_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic               proto_err_q, proto_err_d;
  logic [LAT_W-1:0]   ign_q, ign_d;

  logic tail_v, push, pop, stray, drop;

  // Everything granted but not yet popped holds a FIFO slot in reserve.
  assign credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_cnt_q}) < (CNT_W + 1)'(RSP_DEPTH);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .en        (credit_ok),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign req_ready        = gnt;
  assign dec_valid_in     = dec_valid_in_q;
  assign dec_encoded_data = dec_encoded_data_q;
  assign rsp_valid        = (fifo_cnt_q != '0);
  assign rsp_data         = mem_data_q[rd_ptr_q];
  assign rsp_id           = mem_id_q[rd_ptr_q];
  assign proto_err        = proto_err_q;

  assign tail_v = tag_v_q[DEC_LAT-1];
  assign push   = tail_v & dec_valid_out;
  assign pop    = rsp_valid & rsp_ready;
  assign stray  = dec_valid_out & ~tail_v & (ign_q == '0);
  assign drop   = tail_v & ~dec_valid_out;

  always_comb begin
    dec_valid_in_d     = gnt_valid;
    dec_encoded_data_d = dec_encoded_data_q;
    issue_tag_d        = issue_tag_q;
    if (gnt_valid) begin
      dec_encoded_data_d = req_data[int'(gnt_idx) * ENC_W +: ENC_W];
      issue_tag_d        = gnt_idx;
    end

    // Stage 0 runs alongside the decoder strobe; the tail meets dec_valid_out.
    tag_v_d[0]  = dec_valid_in_q;
    tag_id_d[0] = issue_tag_q;
    for (int i = 1; i < DEC_LAT; i++) begin
      tag_v_d[i]  = tag_v_q[i-1];
      tag_id_d[i] = tag_id_q[i-1];
    end

    inflight_d  = inflight_q + CNT_W'(gnt_valid) - CNT_W'(tail_v);
    fifo_cnt_d  = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    mem_data_d  = mem_data_q;
    mem_id_d    = mem_id_q;
    if (push) begin
      mem_data_d[wr_ptr_q] = dec_decoded_data;
      mem_id_d[wr_ptr_q]   = tag_id_q[DEC_LAT-1];
    end

    proto_err_d = proto_err_q | stray | drop;
    ign_d       = (ign_q != '0) ? ign_q - LAT_W'(1) : ign_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_valid_in_q     <= 1'b0;
      dec_encoded_data_q <= '0;
      issue_tag_q        <= '0;
      for (int i = 0; i < DEC_LAT; i++) begin
        tag_v_q[i]  <= 1'b0;
        tag_id_q[i] <= '0;
      end
      inflight_q <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_id_q[i]   <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      proto_err_q <= 1'b0;
      // Decoder results still in flight across reset must not flag an error.
      ign_q       <= LAT_W'(DEC_LAT + 1);
    end else begin
      dec_valid_in_q     <= dec_valid_in_d;
      dec_encoded_data_q <= dec_encoded_data_d;
      issue_tag_q        <= issue_tag_d;
      tag_v_q            <= tag_v_d;
      tag_id_q           <= tag_id_d;
      inflight_q         <= inflight_d;
      mem_data_q         <= mem_data_d;
      mem_id_q           <= mem_id_d;
      wr_ptr_q           <= wr_ptr_d;
      rd_ptr_q           <= rd_ptr_d;
      fifo_cnt_q         <= fifo_cnt_d;
      proto_err_q        <= proto_err_d;
      ign_q              <= ign_d;
    end
  end

`ifdef HAMMING_ARB_STATS_EN
  logic [15:0] stat_cnt_q [NUM_REQ];
  logic [15:0] stat_cnt_d [NUM_REQ];

  always_comb begin
    stat_cnt_d = stat_cnt_q;
    if (stat_clr) begin
      for (int i = 0; i < NUM_REQ; i++) stat_cnt_d[i] = '0;
    end else if (gnt_valid && (stat_cnt_q[gnt_idx] != 16'hFFFF)) begin
      stat_cnt_d[gnt_idx] = stat_cnt_q[gnt_idx] + 16'd1;
    end
    stat_grants = (int'(stat_sel) < NUM_REQ) ? stat_cnt_q[stat_sel] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) stat_cnt_q[i] <= '0;
    end else begin
      stat_cnt_q <= stat_cnt_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hamming_dec_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_hamming_dec_arbiter
// Randomized scoreboard bench with a behavioural decoder and arbitration model.
// Rev    : 1.0
// ============================================================================
module tb_hamming_dec_arbiter;
  import hamming_pkg::*;

  localparam int NUM_REQ   = 4;
  localparam int RSP_DEPTH = 4;
  localparam int DEC_LAT   = 1;
  localparam int ID_W      = 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ*ENC_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [ENC_W-1:0]         dec_encoded_data;
  logic                     dec_valid_in;
  logic [DATA_W-1:0]        dec_decoded_data;
  logic                     dec_valid_out;
  logic                     rsp_valid;
  logic                     rsp_ready = 1'b0;
  logic [DATA_W-1:0]        rsp_data;
  logic [ID_W-1:0]          rsp_id;
  logic                     proto_err;

  always #5 clk = ~clk;

  hamming_dec_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .RSP_DEPTH (RSP_DEPTH),
    .DEC_LAT   (DEC_LAT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .dec_encoded_data (dec_encoded_data),
    .dec_valid_in     (dec_valid_in),
    .dec_decoded_data (dec_decoded_data),
    .dec_valid_out    (dec_valid_out),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_data         (rsp_data),
    .rsp_id           (rsp_id),
    .proto_err        (proto_err)
  );

  // Behavioural single-error-correcting decoder: syndrome = XOR of set positions.
  function automatic dataword_t ref_decode(input codeword_t cw);
    codeword_t c;
    dataword_t d;
    int        syn;
    int        k;
    c   = cw;
    syn = 0;
    d   = '0;
    for (int p = 1; p <= ENC_W; p++) if (c[p-1]) syn = syn ^ p;
    if (syn >= 1 && syn <= ENC_W) c[syn-1] = ~c[syn-1];
    k = 0;
    for (int p = 1; p <= ENC_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = c[p-1];
        k++;
      end
    end
    return d;
  endfunction

  logic      dvo_r   = 1'b0;
  dataword_t dd_r    = '0;
  logic      inj_dvo = 1'b0;
  logic      inj_req = 1'b0;

  always @(posedge clk) begin
    dvo_r <= dec_valid_in;
    dd_r  <= ref_decode(dec_encoded_data);
  end
  assign dec_valid_out    = dvo_r | inj_dvo;
  assign dec_decoded_data = dd_r;

  typedef struct packed {
    logic [ID_W-1:0] id;
    dataword_t       data;
  } rsp_t;

  rsp_t      sb[$];
  int        checks = 0;
  int        errors = 0;
  int        ptr_m = 0;
  int        outstanding = 0;
  int        grants = 0;
  bit        rand_mode = 1'b0;
  dataword_t pend_data [NUM_REQ];
  codeword_t pend_cw   [NUM_REQ];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic new_pend(input int i);
    codeword_t cw;
    pend_data[i] = dataword_t'($urandom);
    cw = hamming_encode(pend_data[i]);
    if ($urandom_range(0, 3) == 0) cw[$urandom_range(0, ENC_W - 1)] ^= 1'b1;
    pend_cw[i] = cw;
  endtask

  // One cycle: drive at negedge, then check req_ready against the model.
  task automatic step(input logic [NUM_REQ-1:0] v, input logic rr);
    logic [NUM_REQ-1:0] exp_rdy;
    int                 win;
    int                 idx;
    rsp_t               e;
    @(negedge clk);
    inj_dvo = inj_req;
    inj_req = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) req_data[i*ENC_W +: ENC_W] = pend_cw[i];
    req_valid = v;
    rsp_ready = rr;
    #1;
    win = -1;
    if (outstanding < RSP_DEPTH) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (ptr_m + k) % NUM_REQ;
        if (win < 0 && v[idx]) win = idx;
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (win >= 0) begin
      e.id   = ID_W'(win);
      e.data = pend_data[win];
      sb.push_back(e);
      ptr_m = (win + 1) % NUM_REQ;
      outstanding++;
      grants++;
      if (rand_mode) new_pend(win);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    inj_dvo   = 1'b0;
    sb.delete();
    outstanding = 0;
    ptr_m       = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got id %0d data %h expected no response", rsp_id, rsp_data);
        end else begin
          e = sb.pop_front();
          chk("rsp", 32'({rsp_id, rsp_data}), 32'(e));
        end
        outstanding--;
      end
    end
  end

  initial begin : driver
    int g0;
    int n;
    for (int i = 0; i < NUM_REQ; i++) begin
      pend_data[i] = '0;
      pend_cw[i]   = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_dec_valid_in", 32'(dec_valid_in), 32'h0);
    chk("rst_dec_encoded_data", 32'(dec_encoded_data), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("rst_proto_err", 32'(proto_err), 32'h0);
    rst = 1'b0;

    // Single request: latency to decoder and to response.
    pend_data[2] = 16'h1234;
    pend_cw[2]   = hamming_encode(16'h1234);
    step(4'b0100, 1'b1);
    step(4'b0000, 1'b1);
    chk("lat_dec_valid_in", 32'(dec_valid_in), 32'h1);
    chk("lat_dec_encoded_data", 32'(dec_encoded_data), 32'(hamming_encode(16'h1234)));
    step(4'b0000, 1'b1);
    chk("lat_rsp_valid_early", 32'(rsp_valid), 32'h0);
    step(4'b0000, 1'b1);
    chk("lat_rsp_valid", 32'(rsp_valid), 32'h1);
    repeat (3) step(4'b0000, 1'b1);

    // Continuous rotation with all requesters valid.
    for (int i = 0; i < NUM_REQ; i++) begin
      pend_data[i] = dataword_t'(16'h1000 + i);
      pend_cw[i]   = hamming_encode(pend_data[i]);
    end
    g0 = grants;
    repeat (12) step(4'b1111, 1'b1);
    chk("rr_grants", 32'(grants - g0), 32'd12);
    repeat (6) step(4'b0000, 1'b1);

    // Backpressure: credits run out, one pop frees exactly one grant.
    g0 = grants;
    repeat (8) step(4'b1111, 1'b0);
    chk("bp_grants", 32'(grants - g0), 32'd4);
    g0 = grants;
    step(4'b1111, 1'b1);
    repeat (4) step(4'b1111, 1'b0);
    chk("bp_extra_grant", 32'(grants - g0), 32'd1);
    repeat (10) step(4'b0000, 1'b1);
    chk("bp_drained", 32'(sb.size()), 32'd0);

    // Single-bit error corrected by the decoder.
    pend_data[1] = 16'hBEEF;
    pend_cw[1]   = hamming_encode(16'hBEEF);
    pend_cw[1][9] = ~pend_cw[1][9];
    step(4'b0010, 1'b1);
    repeat (5) step(4'b0000, 1'b1);

    // Randomized traffic.
    rand_mode = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) new_pend(i);
    repeat (400) step(NUM_REQ'($urandom), ($urandom_range(0, 3) != 0));
    rand_mode = 1'b0;
    repeat (12) step(4'b0000, 1'b1);
    chk("rand_drained", 32'(sb.size()), 32'd0);
    chk("rand_proto_err", 32'(proto_err), 32'h0);

    // Stray decoder strobe with an empty tag pipe.
    inj_req = 1'b1;
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    chk("proto_err_set", 32'(proto_err), 32'h1);
    chk("proto_rsp_valid", 32'(rsp_valid), 32'h0);
    step(4'b0000, 1'b1);
    chk("proto_err_sticky", 32'(proto_err), 32'h1);
    do_reset();
    chk("proto_err_cleared", 32'(proto_err), 32'h0);

    // Reset with three decodes in flight; strobes right after reset are ignored.
    for (int i = 0; i < NUM_REQ; i++) begin
      pend_data[i] = dataword_t'(16'h2200 + i);
      pend_cw[i]   = hamming_encode(pend_data[i]);
    end
    g0 = grants;
    repeat (3) step(4'b1111, 1'b0);
    chk("mid_grants", 32'(grants - g0), 32'd3);
    do_reset();
    inj_req = 1'b1;
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    chk("mid_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid_proto_err", 32'(proto_err), 32'h0);
    step(4'b0000, 1'b1);
    chk("mid_proto_err_late", 32'(proto_err), 32'h0);
    pend_data[3] = 16'h5A5A;
    pend_cw[3]   = hamming_encode(16'h5A5A);
    step(4'b1000, 1'b1);

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      step(4'b0000, 1'b1);
      n++;
    end
    chk("final_drain", 32'(sb.size()), 32'd0);
    step(4'b0000, 1'b1);
    chk("final_proto_err", 32'(proto_err), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hamming_dec_arbiter.md
Name: hamming_dec_arbiter

Overview:
Shares one Hamming(21,16) decode unit (`decode`) between NUM_REQ requesters. Each requester offers a 21-bit codeword with valid/ready. The block picks one per cycle by round-robin, drives the decoder, and tracks each request's requester ID through the decoder's fixed latency. Decoded words are returned through a credit-protected response FIFO with valid/ready backpressure. It sits between the link receive lanes and the payload consumer.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- RSP_DEPTH, 4: response FIFO entries, power of 2, ≥2.
- DEC_LAT, 1: cycles from dec_valid_in to dec_valid_out, ≥1.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester codeword valid.
- req_data  in  NUM_REQ*21  packed codewords; requester i at [21*i+:21].
- req_ready  out  NUM_REQ  one-hot accept; combinational from req_valid and state.
- dec_encoded_data  out  21  codeword to decoder (registered).
- dec_valid_in  out  1  decoder strobe (registered).
- dec_decoded_data  in  16  decoder result.
- dec_valid_out  in  1  decoder result valid.
- rsp_valid  out  1  FIFO head valid.
- rsp_ready  in  1  consumer accepts head.
- rsp_data  out  16  decoded word.
- rsp_id  out  $clog2(NUM_REQ)  originating requester.
- proto_err  out  1  sticky decoder-protocol error.

Behaviour:
- Reset values:
  - req_ready=0, dec_valid_in=0, dec_encoded_data=0.
  - rsp_valid=0, rsp_data=0, rsp_id=0, proto_err=0.
  - RR pointer=0, inflight=0, FIFO empty, tag pipe cleared.
- Credit check: a grant is allowed only when inflight + fifo_count < RSP_DEPTH. The FIFO can therefore never overflow.
- Arbitration (cycle T):
  - Search req_valid starting at the RR pointer, wrapping modulo NUM_REQ.
  - First set bit wins, if credit allows. req_ready[g]=1 only for the winner.
  - Handshake completes when req_valid[g] & req_ready[g].
- Pointer update: after a grant, pointer ← (g+1) mod NUM_REQ. With no grant it is unchanged.
- Issue (T+1): dec_encoded_data ← winner's codeword, dec_valid_in=1, and tag g enters a DEC_LAT-deep tag pipe. inflight increments at grant.
- Return (T+1+DEC_LAT): when dec_valid_out=1 and the tag-pipe tail is valid, {tail_tag, dec_decoded_data} is pushed to the FIFO. inflight decrements.
- Response latency: rsp_valid rises no earlier than T+2+DEC_LAT.
- Throughput: one grant per cycle sustained while credit remains.
- FIFO:
  - Registered head drives rsp_valid, rsp_data and rsp_id.
  - Pop on rsp_valid & rsp_ready.
  - Push and pop in the same cycle keep the count unchanged, including when full.
  - Pop when empty is impossible (rsp_valid=0).
- Ordering: responses leave in grant order. Same-requester order is preserved.
- Protocol errors:
  - dec_valid_out=1 with the tail invalid: proto_err←1 and the data is discarded.
  - Tail valid with dec_valid_out=0: proto_err←1 and the slot is dropped. inflight decrements so credit is never lost.
  - proto_err clears only on rst.
- Reset mid-operation: FIFO, tag pipe and inflight are flushed. For DEC_LAT+1 cycles after rst deasserts, stray dec_valid_out is ignored and does not set proto_err.
- Simultaneous req_valid on all inputs: strict rotation. No requester waits more than NUM_REQ grants.

Optional Feature:
HAMMING_ARB_STATS_EN:
- Enabled:
  - Adds input stat_sel [$clog2(NUM_REQ)], output stat_grants [16], and input stat_clr [1].
  - Per-requester saturating 16-bit grant counters (stick at 0xFFFF).
  - stat_grants = counter[stat_sel], combinational read.
  - stat_clr zeroes all counters synchronously. A grant in the same cycle is lost.
- Disabled: these ports and counters do not exist. Core behaviour is identical.

Decomposition:
- Package hamming_pkg:
  - DATA_W=16, ENC_W=21.
  - typedefs codeword_t [20:0] and dataword_t [15:0].
  - Function hamming_encode for bench and model use.
- One sub-module: rr_arbiter (NUM_REQ parameter; req vector plus enable in; one-hot grant plus index out; owns the pointer).
- FIFO and tag pipe stay inline.

Test Plan:
- Single request: req 2 sends encode(0x1234) at T → dec_valid_in at T+1 → rsp_valid at T+3 with rsp_data=0x1234, rsp_id=2. Run with NUM_REQ=4, RSP_DEPTH=4, DEC_LAT=1.
- Round-robin: all 4 requesters valid continuously with encode(0x1000+i), rsp_ready=1 → grants 0,1,2,3,0,…, one per cycle, and rsp_id follows the same sequence.
- Backpressure: rsp_ready=0, all requesters valid → exactly 4 grants, then req_ready=0 held. Raising rsp_ready for one cycle → exactly one further grant, and no data is lost.
- Single-bit error: req 1 sends encode(0xBEEF) with bit 9 flipped → rsp_data=0xBEEF, rsp_id=1.
- Protocol error: inject dec_valid_out with an empty tag pipe → proto_err=1, FIFO count unchanged. Assert rst → proto_err=0.
- Reset mid-flight: 3 grants outstanding, rst pulsed for 1 cycle → rsp_valid=0 afterwards, stray dec_valid_out ignored, proto_err stays 0, next request returns normally.
